// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter
//   Two-master Wishbone classic arbiter. It shares one memory slave port
//   between the core (M0) and the UART-Wishbone bridge (M1). Arbitration is
//   round-robin. The owner keeps the bus for its whole CYC. Acks and read
//   data go only to the owner.
//
//   Ports
//     clk, rst              clock, synchronous active-high reset
//     i_mX_cyc/stb/we       master X request (X = 0 core, 1 UART bridge)
//     i_mX_adr/dat/sel      master X address, write data, byte enables
//     o_mX_dat/ack/err      read data, ack, abort back to master X
//     o_s_cyc/stb/we        to memory slave
//     o_s_adr/dat/sel       to memory slave
//     i_s_dat/ack           from memory slave
//     o_grant               one-hot owner {M1,M0}, 2'b00 when idle
//
//   Optional feature: define ARB_TIMEOUT_EN to enable the stall timeout.
//   When enabled, an owner whose strobe goes unacked for TIMEOUT_CYCLES
//   cycles gets a one-cycle err pulse. The bus is then parked in ABORT until
//   that owner drops cyc.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | no owner, slave port quiet, arbitrate registered requests
//   GNT_M0   | core owns the slave port until it drops cyc
//   GNT_M1   | UART bridge owns the slave port until it drops cyc
//   ABORT    | (ARB_TIMEOUT_EN) timed-out owner, bus parked until cyc drops

module wb_mem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_m0_cyc,
  input  logic                      i_m0_stb,
  input  logic                      i_m0_we,
  input  logic [ADDR_WIDTH-1:0]     i_m0_adr,
  input  logic [DATA_WIDTH-1:0]     i_m0_dat,
  input  logic [DATA_WIDTH/8-1:0]   i_m0_sel,
  output logic [DATA_WIDTH-1:0]     o_m0_dat,
  output logic                      o_m0_ack,
  output logic                      o_m0_err,
  input  logic                      i_m1_cyc,
  input  logic                      i_m1_stb,
  input  logic                      i_m1_we,
  input  logic [ADDR_WIDTH-1:0]     i_m1_adr,
  input  logic [DATA_WIDTH-1:0]     i_m1_dat,
  input  logic [DATA_WIDTH/8-1:0]   i_m1_sel,
  output logic [DATA_WIDTH-1:0]     o_m1_dat,
  output logic                      o_m1_ack,
  output logic                      o_m1_err,
  output logic                      o_s_cyc,
  output logic                      o_s_stb,
  output logic                      o_s_we,
  output logic [ADDR_WIDTH-1:0]     o_s_adr,
  output logic [DATA_WIDTH-1:0]     o_s_dat,
  output logic [DATA_WIDTH/8-1:0]   o_s_sel,
  input  logic [DATA_WIDTH-1:0]     i_s_dat,
  input  logic                      i_s_ack,
  output logic [1:0]                o_grant
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_mem_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

`ifdef ARB_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_GNT_M0, ST_GNT_M1, ST_ABORT} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_GNT_M0, ST_GNT_M1} state_t;
`endif

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;   // 1 = M1 was the last owner
  logic   req_m0, req_m1;

  assign req_m0 = i_m0_cyc & i_m0_stb;
  assign req_m1 = i_m1_cyc & i_m1_stb;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] timeout_cnt;
  logic        owner_m1;     // remembers who to release from ABORT
  logic        timeout_hit;

  assign timeout_hit = (timeout_cnt == TIMEOUT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_cnt <= '0;
      owner_m1    <= 1'b0;
    end else begin
      if ((state != ST_GNT_M0 && state != ST_GNT_M1) || i_s_ack)
        timeout_cnt <= '0;
      else if (o_s_stb)
        timeout_cnt <= timeout_cnt + 16'd1;
      if (state == ST_GNT_M1)
        owner_m1 <= 1'b1;
      else if (state == ST_GNT_M0)
        owner_m1 <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    o_s_cyc        = 1'b0;
    o_s_stb        = 1'b0;
    o_s_we         = 1'b0;
    o_s_adr        = '0;
    o_s_dat        = '0;
    o_s_sel        = '0;
    o_m0_dat       = '0;
    o_m0_ack       = 1'b0;
    o_m0_err       = 1'b0;
    o_m1_dat       = '0;
    o_m1_ack       = 1'b0;
    o_m1_err       = 1'b0;
    o_grant        = 2'b00;
    case (state)
      ST_IDLE: begin
        // On contention the master that did not own the bus last wins.
        if (req_m0 && (!req_m1 || last_grant))
          state_nxt = ST_GNT_M0;
        else if (req_m1)
          state_nxt = ST_GNT_M1;
      end
      ST_GNT_M0: begin
        o_grant  = 2'b01;
        o_s_cyc  = i_m0_cyc;
        o_s_stb  = i_m0_stb;
        o_s_we   = i_m0_we;
        o_s_adr  = i_m0_adr;
        o_s_dat  = i_m0_dat;
        o_s_sel  = i_m0_sel;
        o_m0_dat = i_s_dat;
        // An ack arriving after the owner dropped cyc is a stale one.
        o_m0_ack = i_s_ack & i_m0_cyc;
        if (!i_m0_cyc) begin
          state_nxt      = ST_IDLE;
          last_grant_nxt = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          o_s_cyc   = 1'b0;
          o_s_stb   = 1'b0;
          o_m0_ack  = 1'b0;
          o_m0_err  = 1'b1;
          state_nxt = ST_ABORT;
        end
`endif
      end
      ST_GNT_M1: begin
        o_grant  = 2'b10;
        o_s_cyc  = i_m1_cyc;
        o_s_stb  = i_m1_stb;
        o_s_we   = i_m1_we;
        o_s_adr  = i_m1_adr;
        o_s_dat  = i_m1_dat;
        o_s_sel  = i_m1_sel;
        o_m1_dat = i_s_dat;
        o_m1_ack = i_s_ack & i_m1_cyc;
        if (!i_m1_cyc) begin
          state_nxt      = ST_IDLE;
          last_grant_nxt = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          o_s_cyc   = 1'b0;
          o_s_stb   = 1'b0;
          o_m1_ack  = 1'b0;
          o_m1_err  = 1'b1;
          state_nxt = ST_ABORT;
        end
`endif
      end
`ifdef ARB_TIMEOUT_EN
      ST_ABORT: begin
        if (!(owner_m1 ? i_m1_cyc : i_m0_cyc)) begin
          state_nxt      = ST_IDLE;
          last_grant_nxt = owner_m1;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter
//   Directed testbench for wb_mem_arbiter. Inputs change on the falling
//   edge. Outputs are checked 1 ns later, well away from the rising edge.
//   Build with ARB_TIMEOUT_EN defined to exercise the timeout path
//   (TIMEOUT_CYCLES = 8).

module tb_wb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_m0_cyc, i_m0_stb, i_m0_we;
  logic [AW-1:0] i_m0_adr;
  logic [DW-1:0] i_m0_dat;
  logic [SW-1:0] i_m0_sel;
  logic [DW-1:0] o_m0_dat;
  logic          o_m0_ack, o_m0_err;
  logic          i_m1_cyc, i_m1_stb, i_m1_we;
  logic [AW-1:0] i_m1_adr;
  logic [DW-1:0] i_m1_dat;
  logic [SW-1:0] i_m1_sel;
  logic [DW-1:0] o_m1_dat;
  logic          o_m1_ack, o_m1_err;
  logic          o_s_cyc, o_s_stb, o_s_we;
  logic [AW-1:0] o_s_adr;
  logic [DW-1:0] o_s_dat;
  logic [SW-1:0] o_s_sel;
  logic [DW-1:0] i_s_dat;
  logic          i_s_ack;
  logic [1:0]    o_grant;

  int n_checks = 0;
  int n_fail   = 0;

  wb_mem_arbiter #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_m0_cyc (i_m0_cyc),
    .i_m0_stb (i_m0_stb),
    .i_m0_we  (i_m0_we),
    .i_m0_adr (i_m0_adr),
    .i_m0_dat (i_m0_dat),
    .i_m0_sel (i_m0_sel),
    .o_m0_dat (o_m0_dat),
    .o_m0_ack (o_m0_ack),
    .o_m0_err (o_m0_err),
    .i_m1_cyc (i_m1_cyc),
    .i_m1_stb (i_m1_stb),
    .i_m1_we  (i_m1_we),
    .i_m1_adr (i_m1_adr),
    .i_m1_dat (i_m1_dat),
    .i_m1_sel (i_m1_sel),
    .o_m1_dat (o_m1_dat),
    .o_m1_ack (o_m1_ack),
    .o_m1_err (o_m1_err),
    .o_s_cyc  (o_s_cyc),
    .o_s_stb  (o_s_stb),
    .o_s_we   (o_s_we),
    .o_s_adr  (o_s_adr),
    .o_s_dat  (o_s_dat),
    .o_s_sel  (o_s_sel),
    .i_s_dat  (i_s_dat),
    .i_s_ack  (i_s_ack),
    .o_grant  (o_grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_m0_we = 1'b0;
    i_m0_adr = '0;   i_m0_dat = '0;   i_m0_sel = '0;
    i_m1_cyc = 1'b0; i_m1_stb = 1'b0; i_m1_we = 1'b0;
    i_m1_adr = '0;   i_m1_dat = '0;   i_m1_sel = '0;
    i_s_ack  = 1'b0; i_s_dat  = '0;
  endtask

  // Drop every request. On return the arbiter is back in IDLE.
  task automatic release_all();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    i_s_ack = 1'b1;
    i_s_dat = 32'hFFFF_FFFF;
    tick(); tick();
    #1;
    n_checks++; if (o_grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", o_grant); end
    n_checks++; if (o_s_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_s_cyc: got %b want 0", o_s_cyc); end
    n_checks++; if (o_m0_ack !== 1'b0 || o_m1_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got m0=%b m1=%b want 0 0", o_m0_ack, o_m1_ack); end
    n_checks++; if (o_m0_dat !== 32'h0 || o_m1_dat !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got m0=%h m1=%h want 0 0", o_m0_dat, o_m1_dat); end
    n_checks++; if (o_m0_err !== 1'b0 || o_m1_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got m0=%b m1=%b want 0 0", o_m0_err, o_m1_err); end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_single_write();
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_we = 1'b1;
    i_m0_adr = 32'h0; i_m0_dat = 32'h0000_0093; i_m0_sel = 4'hF;
    #1;
    n_checks++; if (o_grant !== 2'b00 || o_s_stb !== 1'b0) begin n_fail++; $display("FAIL wr_req_cycle: got grant=%b stb=%b want 00 0", o_grant, o_s_stb); end
    tick();
    i_s_ack = 1'b1;
    #1;
    n_checks++; if (o_grant !== 2'b01) begin n_fail++; $display("FAIL wr_grant: got %b want 01", o_grant); end
    n_checks++; if (o_s_stb !== 1'b1 || o_s_we !== 1'b1 || o_s_adr !== 32'h0) begin n_fail++; $display("FAIL wr_s_ctl: got stb=%b we=%b adr=%h want 1 1 0", o_s_stb, o_s_we, o_s_adr); end
    n_checks++; if (o_s_dat !== 32'h0000_0093 || o_s_sel !== 4'hF) begin n_fail++; $display("FAIL wr_s_data: got dat=%h sel=%h want 00000093 f", o_s_dat, o_s_sel); end
    n_checks++; if (o_m0_ack !== 1'b1 || o_m1_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack: got m0=%b m1=%b want 1 0", o_m0_ack, o_m1_ack); end
    tick();
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_s_ack = 1'b0;
    #1;
    n_checks++; if (o_m0_ack !== 1'b0 || o_s_cyc !== 1'b0) begin n_fail++; $display("FAIL wr_release: got ack=%b s_cyc=%b want 0 0", o_m0_ack, o_s_cyc); end
    tick();
    #1;
    n_checks++; if (o_grant !== 2'b00) begin n_fail++; $display("FAIL wr_idle: got %b want 00", o_grant); end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_we = 1'b0; i_m0_adr = 32'h4;
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_we = 1'b1; i_m1_adr = 32'h8; i_m1_dat = 32'h55;
    #1;
    n_checks++; if (o_grant !== 2'b00) begin n_fail++; $display("FAIL both_req_cycle: got %b want 00", o_grant); end
    tick();
    i_s_ack = 1'b1;
    #1;
    n_checks++; if (o_grant !== 2'b01 || o_s_adr !== 32'h4) begin n_fail++; $display("FAIL both_first_m0: got grant=%b adr=%h want 01 4", o_grant, o_s_adr); end
    n_checks++; if (o_m0_ack !== 1'b1 || o_m1_ack !== 1'b0) begin n_fail++; $display("FAIL both_ack_route: got m0=%b m1=%b want 1 0", o_m0_ack, o_m1_ack); end
    tick();
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_s_ack = 1'b0;
    #1;
    n_checks++; if (o_grant !== 2'b01 || o_s_cyc !== 1'b0) begin n_fail++; $display("FAIL both_drop: got grant=%b s_cyc=%b want 01 0", o_grant, o_s_cyc); end
    tick();
    #1;
    n_checks++; if (o_grant !== 2'b00 || o_s_stb !== 1'b0) begin n_fail++; $display("FAIL both_bubble: got grant=%b stb=%b want 00 0", o_grant, o_s_stb); end
    tick();
    #1;
    n_checks++; if (o_grant !== 2'b10 || o_s_adr !== 32'h8 || o_s_dat !== 32'h55) begin n_fail++; $display("FAIL both_then_m1: got grant=%b adr=%h dat=%h want 10 8 55", o_grant, o_s_adr, o_s_dat); end
    release_all();
  endtask

  task automatic test_locked_burst();
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_we = 1'b1; i_m1_sel = 4'hF;
    tick();
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_adr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      i_m1_adr = 32'(i * 4);
      i_m1_dat = 32'(i + 1);
      i_s_ack  = 1'b1;
      #1;
      n_checks++; if (o_grant !== 2'b10 || o_s_adr !== 32'(i * 4)) begin n_fail++; $display("FAIL burst_owner[%0d]: got grant=%b adr=%h want 10 %h", i, o_grant, o_s_adr, 32'(i * 4)); end
      n_checks++; if (o_m1_ack !== 1'b1 || o_m0_ack !== 1'b0) begin n_fail++; $display("FAIL burst_ack[%0d]: got m1=%b m0=%b want 1 0", i, o_m1_ack, o_m0_ack); end
      tick();
    end
    i_m1_cyc = 1'b0; i_m1_stb = 1'b0; i_s_ack = 1'b0;
    #1;
    n_checks++; if (o_grant !== 2'b10 || o_m0_ack !== 1'b0) begin n_fail++; $display("FAIL burst_release: got grant=%b m0_ack=%b want 10 0", o_grant, o_m0_ack); end
    tick();
    #1;
    n_checks++; if (o_grant !== 2'b00) begin n_fail++; $display("FAIL burst_bubble: got %b want 00", o_grant); end
    tick();
    #1;
    n_checks++; if (o_grant !== 2'b01 || o_s_adr !== 32'h40) begin n_fail++; $display("FAIL burst_m0_after: got grant=%b adr=%h want 01 40", o_grant, o_s_adr); end
    release_all();
  endtask

  task automatic test_read_route();
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_we = 1'b0; i_m1_adr = 32'h10;
    tick();
    i_s_dat = 32'hDEAD_BEEF;
    i_s_ack = 1'b1;
    #1;
    n_checks++; if (o_m1_dat !== 32'hDEAD_BEEF || o_m1_ack !== 1'b1) begin n_fail++; $display("FAIL rd_m1: got dat=%h ack=%b want deadbeef 1", o_m1_dat, o_m1_ack); end
    n_checks++; if (o_m0_dat !== 32'h0 || o_m0_ack !== 1'b0) begin n_fail++; $display("FAIL rd_m0_quiet: got dat=%h ack=%b want 0 0", o_m0_dat, o_m0_ack); end
    n_checks++; if (o_s_we !== 1'b0 || o_s_adr !== 32'h10) begin n_fail++; $display("FAIL rd_s_ctl: got we=%b adr=%h want 0 10", o_s_we, o_s_adr); end
    release_all();
    // Lone M1 re-requests right after owning the bus and wins again.
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_adr = 32'h14;
    tick();
    #1;
    n_checks++; if (o_grant !== 2'b10) begin n_fail++; $display("FAIL rd_rewin: got %b want 10", o_grant); end
    // Abandon the strobe unacked; an ack arriving afterwards must not leak.
    i_m1_cyc = 1'b0; i_m1_stb = 1'b0; i_s_ack = 1'b1;
    #1;
    n_checks++; if (o_m1_ack !== 1'b0) begin n_fail++; $display("FAIL rd_late_ack_drop: got %b want 0", o_m1_ack); end
    tick();
    #1;
    n_checks++; if (o_grant !== 2'b00 || o_m1_ack !== 1'b0 || o_m0_ack !== 1'b0) begin n_fail++; $display("FAIL rd_late_ack_idle: got grant=%b m1=%b m0=%b want 00 0 0", o_grant, o_m1_ack, o_m0_ack); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_adr = 32'h20;
    tick();
    #1;
    n_checks++; if (o_grant !== 2'b01 || o_s_stb !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got grant=%b stb=%b want 01 1", o_grant, o_s_stb); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_s_ack = 1'b1;
    #1;
    n_checks++; if (o_grant !== 2'b00 || o_s_cyc !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got grant=%b s_cyc=%b want 00 0", o_grant, o_s_cyc); end
    n_checks++; if (o_m0_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_ack: got %b want 0", o_m0_ack); end
    release_all();
  endtask

  task automatic test_timeout();
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_we = 1'b0; i_m0_adr = 32'h30;
    tick();
    #1;
    n_checks++; if (o_grant !== 2'b01) begin n_fail++; $display("FAIL to_grant: got %b want 01", o_grant); end
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++; if (o_m0_err !== 1'b0 || o_s_stb !== 1'b1) begin n_fail++; $display("FAIL to_wait[%0d]: got err=%b stb=%b want 0 1", k, o_m0_err, o_s_stb); end
      tick();
    end
    #1;
    n_checks++; if (o_m0_err !== 1'b1 || o_s_cyc !== 1'b0 || o_s_stb !== 1'b0) begin n_fail++; $display("FAIL to_fire: got err=%b cyc=%b stb=%b want 1 0 0", o_m0_err, o_s_cyc, o_s_stb); end
    n_checks++; if (o_m1_err !== 1'b0) begin n_fail++; $display("FAIL to_m1_err: got %b want 0", o_m1_err); end
    tick();
    #1;
    n_checks++; if (o_m0_err !== 1'b0 || o_s_cyc !== 1'b0) begin n_fail++; $display("FAIL to_abort1: got err=%b cyc=%b want 0 0", o_m0_err, o_s_cyc); end
    tick();
    #1;
    n_checks++; if (o_s_cyc !== 1'b0 || o_s_stb !== 1'b0) begin n_fail++; $display("FAIL to_abort2: got cyc=%b stb=%b want 0 0", o_s_cyc, o_s_stb); end
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
    tick();
    #1;
    n_checks++; if (o_grant !== 2'b00) begin n_fail++; $display("FAIL to_idle: got %b want 00", o_grant); end
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1;
    tick();
    #1;
    n_checks++; if (o_grant !== 2'b10) begin n_fail++; $display("FAIL to_next_owner: got %b want 10", o_grant); end
`else
    for (int k = 0; k < 20; k++) begin
      #1;
      n_checks++; if (o_m0_err !== 1'b0 || o_m1_err !== 1'b0) begin n_fail++; $display("FAIL stall_err[%0d]: got m0=%b m1=%b want 0 0", k, o_m0_err, o_m1_err); end
      tick();
    end
    #1;
    n_checks++; if (o_grant !== 2'b01 || o_s_stb !== 1'b1) begin n_fail++; $display("FAIL stall_held: got grant=%b stb=%b want 01 1", o_grant, o_s_stb); end
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
    tick();
    #1;
    n_checks++; if (o_grant !== 2'b00) begin n_fail++; $display("FAIL stall_release: got %b want 00", o_grant); end
`endif
    release_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_locked_burst();
    test_read_route();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
